// File: rtl/br_param.sv
// br_param: multi-port register file with byte-enable writes, optional write bypass
// and a one-register-per-cycle clear sweep that also serves as reset initialisation.
module br_param #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NRD = 2,
    parameter bit ZERO_REG = 1,
    parameter bit BYPASS = 1,
    localparam int AW = $clog2(NREGS),
    localparam int BE = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [XLEN-1:0]   wd,
    input  logic [BE-1:0]     wbe,
    output logic              busy
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [XLEN-1:0] mem [NREGS];
    logic [XLEN-1:0] wmask;
    assign busy = state == CLEAR;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        if (state == IDLE && clr) begin
            state_n = CLEAR;
            cnt_n = '0;
        end else if (state == CLEAR) begin
            cnt_n = cnt + 1'b1;
            state_n = cnt == AW'(NREGS - 1) ? IDLE : CLEAR;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    // Storage has no reset; the sweep is the only initialisation.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[cnt] <= '0;
        else if (!rst && we && !(ZERO_REG && wa == '0))
            for (int b = 0; b < BE; b++)
                if (wbe[b]) mem[wa][8*b +: 8] <= wd[8*b +: 8];
    end
    always_comb begin
        wmask = '0;
        for (int b = 0; b < BE; b++)
            wmask[8*b +: 8] = {8{wbe[b]}};
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic [XLEN-1:0] s;
        assign a = ra[k*AW +: AW];
        assign s = mem[a];
        assign rd[k*XLEN +: XLEN] = (busy || (ZERO_REG && a == '0)) ? '0
            : (BYPASS && we && a == wa) ? (wd & wmask) | (s & ~wmask) : s;
    end
endmodule

// File: tb/tb_br_param.sv
// tb_br_param: directed scoreboard bench for br_param (default, no-bypass and 8x3 builds).
module tb_br_param;
    logic clk = 0;
    always #5 clk = ~clk;
    logic rst, clr, we;
    logic [9:0] ra;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [3:0] wbe;
    logic [63:0] rd_a, rd_b;
    logic busy_a, busy_b;
    logic [8:0] ra_c;
    logic [95:0] rd_c;
    logic busy_c;
    logic [2:0] wa_c;
    logic [31:0] wd_c;
    logic [3:0] wbe_c;
    logic we_c, clr_c;

    br_param dut_a (.clk(clk), .rst(rst), .clr(clr), .ra(ra), .rd(rd_a), .we(we),
                    .wa(wa), .wd(wd), .wbe(wbe), .busy(busy_a));
    br_param #(.BYPASS(0)) dut_b (.clk(clk), .rst(rst), .clr(clr), .ra(ra), .rd(rd_b), .we(we),
                    .wa(wa), .wd(wd), .wbe(wbe), .busy(busy_b));
    br_param #(.NREGS(8), .NRD(3)) dut_c (.clk(clk), .rst(rst), .clr(clr_c), .ra(ra_c), .rd(rd_c),
                    .we(we_c), .wa(wa_c), .wd(wd_c), .wbe(wbe_c), .busy(busy_c));

    logic [95:0] exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [95:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [95:0] obs);
        logic [95:0] e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic sweep_len(output int n);
        n = 0;
        while (busy_a && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n, nc;
        rst = 1; clr = 0; we = 0; ra = '0; wa = '0; wd = '0; wbe = '0;
        ra_c = '0; we_c = 0; clr_c = 0; wa_c = '0; wd_c = '0; wbe_c = '0;
        tick();
        rst = 0;
        push(1); check("reset_busy", 96'(busy_a));
        n = 0; nc = 0;
        while ((busy_a || busy_c) && n < 200) begin
            if (busy_a) n++;
            if (busy_c) nc++;
            tick();
        end
        push(32); check("reset_sweep_len", 96'(n));
        push(8); check("reset_sweep_len_c", 96'(nc));
        for (int i = 0; i < 32; i++) begin
            ra = {5'(i), 5'(31 - i)};
            #1;
            push(0); check("reset_reg_zero", 96'(rd_a));
        end
        for (int i = 0; i < 8; i++) begin
            ra_c = {3'(i), 3'(7 - i), 3'(i)};
            #1;
            push(0); check("reset_reg_zero_c", rd_c);
        end

        we = 1; wa = 5; wd = 32'hDEADBEEF; wbe = 4'hF;
        tick();
        wd = 32'h11223344; wbe = 4'h3;
        tick();
        we = 0; ra = {5'd5, 5'd5};
        #1;
        push({32'hDEAD3344, 32'hDEAD3344}); check("byte_merge", 96'(rd_a));
        push({32'hDEAD3344, 32'hDEAD3344}); check("byte_merge_b", 96'(rd_b));
        we = 1; wd = 32'h0; wbe = 4'h0;
        tick();
        we = 0;
        push(32'hDEAD3344); check("wbe_zero", 96'(rd_a[31:0]));

        ra = {5'd7, 5'd7}; we = 1; wa = 7; wd = 32'hA5A5A5A5; wbe = 4'hF;
        #1;
        push({32'hA5A5A5A5, 32'hA5A5A5A5}); check("bypass_on", 96'(rd_a));
        push(0); check("bypass_off", 96'(rd_b));
        tick();
        we = 0;
        #1;
        push({32'hA5A5A5A5, 32'hA5A5A5A5}); check("no_bypass_after_edge", 96'(rd_b));
        ra = {5'd5, 5'd7}; we = 1; wa = 5; wd = 32'h77000000; wbe = 4'b1000;
        #1;
        push({32'h77AD3344, 32'hA5A5A5A5}); check("bypass_partial", 96'(rd_a));
        push({32'hDEAD3344, 32'hA5A5A5A5}); check("no_bypass_partial", 96'(rd_b));
        tick();
        we = 0;

        ra = {5'd0, 5'd0}; we = 1; wa = 0; wd = 32'hFFFFFFFF; wbe = 4'hF;
        #1;
        push(0); check("zero_reg_same_cycle", 96'(rd_a));
        tick();
        we = 0;
        #1;
        push(0); check("zero_reg_after", 96'(rd_a));
        push(0); check("zero_reg_after_b", 96'(rd_b));

        we = 1; wa = 3; wd = 32'h12345678; wbe = 4'hF;
        tick();
        we = 0; ra = {5'd3, 5'd3};
        #1;
        push({32'h12345678, 32'h12345678}); check("r3_written", 96'(rd_a));
        clr = 1;
        tick();
        clr = 0; we = 1; wa = 3; wd = 32'hFFFFFFFF;
        n = 0;
        while (busy_a && n < 200) begin
            n++;
            clr = n == 5;
            if (n == 10) begin
                push(0); check("rd_zero_busy", 96'(rd_a));
            end
            tick();
        end
        we = 0; clr = 0;
        #1;
        push(32); check("clr_sweep_len", 96'(n));
        push(0); check("r3_cleared", 96'(rd_a));

        we = 1; wa = 9; wd = 32'hCAFEBABE; wbe = 4'hF; clr = 1;
        tick();
        we = 0; clr = 0; ra = {5'd9, 5'd9};
        push(1); check("clr_we_busy", 96'(busy_a));
        sweep_len(n);
        push(32); check("clr_we_sweep_len", 96'(n));
        push(0); check("clr_we_r9_zero", 96'(rd_a));

        we = 1; wa = 4; wd = 32'h00000001; wbe = 4'hF;
        tick();
        we = 0; ra = {5'd4, 5'd4};
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        sweep_len(n);
        push(32); check("rst_mid_sweep_len", 96'(n));
        push(0); check("rst_mid_r4_zero", 96'(rd_a));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
